// File: rtl/divider_pkg.sv
// Shared types and default sizing for the edge-counting divider.
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int DEF_WIDTH       = 32;
   localparam int DEF_REP_WIDTH   = 16;
   localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer with registered rising-edge detect.
module edge_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sig_in,
   output logic edge_pulse
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   logic              pulse_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= '0;
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[STAGES-2:0], sig_in};
         prev_q  <= sync_q[STAGES-1];
         pulse_q <= sync_q[STAGES-1] & ~prev_q;
      end
   end

   assign edge_pulse = pulse_q;

endmodule

// File: rtl/divider_controller.sv
// Divides synchronized sig_in rising edges by a programmed divisor,
// for a programmed number of periods or free-running.
module divider_controller
   import divider_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int REP_WIDTH   = DEF_REP_WIDTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 sig_in,
   input  logic                 start,
   input  logic                 stop,
   input  logic [WIDTH-1:0]     cfg_divisor,
   input  logic [REP_WIDTH-1:0] cfg_repeat,
   output logic                 busy,
   output logic                 div_out,
   output logic                 done,
   output logic                 cfg_error,
   output logic [REP_WIDTH-1:0] period_count
);

   logic edge_pulse;

   edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk        (clk),
      .reset_n    (reset_n),
      .sig_in     (sig_in),
      .edge_pulse (edge_pulse)
   );

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     div_q, div_d;
   logic [REP_WIDTH-1:0] rep_q, rep_d;
   logic [REP_WIDTH-1:0] pc_q, pc_d;
   logic                 busy_q, busy_d;
   logic                 dout_q, dout_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      rep_d   = rep_q;
      pc_d    = pc_q;
      dout_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start && !stop) begin
               if (cfg_divisor == '0) begin
                  err_d = 1'b1;
               end else begin
                  div_d   = cfg_divisor;
                  rep_d   = cfg_repeat;
                  cnt_d   = '0;
                  pc_d    = '0;
                  state_d = COUNT;
               end
            end
         end
         COUNT: begin
            // stop wins over a coincident edge
            if (stop) begin
               state_d = IDLE;
            end else if (edge_pulse) begin
               if (cnt_q + WIDTH'(1) == div_q) begin
                  cnt_d  = '0;
                  dout_d = 1'b1;
                  pc_d   = pc_q + REP_WIDTH'(1);
                  if (rep_q != '0 && pc_d == rep_q)
                     state_d = DONE;
               end else begin
                  cnt_d = cnt_q + WIDTH'(1);
               end
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // busy stays up through DONE so it falls together with done
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         rep_q   <= '0;
         pc_q    <= '0;
         busy_q  <= 1'b0;
         dout_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         rep_q   <= rep_d;
         pc_q    <= pc_d;
         busy_q  <= busy_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign busy         = busy_q;
   assign div_out      = dout_q;
   assign done         = done_q;
   assign cfg_error    = err_q;
   assign period_count = pc_q;

endmodule

// File: tb/tb_divider_controller.sv
// Directed self-checking bench for divider_controller.
module tb_divider_controller;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        sig_in = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [31:0] cfg_divisor = '0;
   logic [15:0] cfg_repeat = '0;
   logic        busy, div_out, done, cfg_error;
   logic [15:0] period_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_div, n_done, n_err, n_edges, last_div, done_gap;
   logic [31:0] mask;
   logic busy_at_done;

   always #5 clk = ~clk;

   divider_controller dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sig_in       (sig_in),
      .start        (start),
      .stop         (stop),
      .cfg_divisor  (cfg_divisor),
      .cfg_repeat   (cfg_repeat),
      .busy         (busy),
      .div_out      (div_out),
      .done         (done),
      .cfg_error    (cfg_error),
      .period_count (period_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (div_out) begin
         n_div++;
         mask |= 32'(1) << n_edges;
         last_div = cyc;
      end
      if (done) begin
         n_done++;
         done_gap = cyc - last_div;
         busy_at_done = busy;
      end
      if (cfg_error) n_err++;
   endtask

   task automatic clr();
      n_div = 0; n_done = 0; n_err = 0; n_edges = 0;
      mask = '0; last_div = 0; done_gap = -1; busy_at_done = 1'b1;
   endtask

   task automatic edge_in();
      sig_in = 1'b1;
      n_edges++;
      repeat (3) step();
      sig_in = 1'b0;
      repeat (3) step();
   endtask

   task automatic go(input logic [31:0] d, input logic [15:0] r);
      cfg_divisor = d;
      cfg_repeat  = r;
      start = 1'b1;
      step();
      start = 1'b0;
      cfg_divisor = '0;
      cfg_repeat  = '0;
   endtask

   initial begin
      clr();
      repeat (3) step();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_outs", {29'd0, div_out, done, cfg_error}, 0);
      chk("rst_pc", 32'(period_count), 0);
      reset_n = 1'b1;
      step();

      // divisor 4, repeat 3
      clr();
      go(4, 3);
      chk("t1_busy_up", 32'(busy), 1);
      repeat (12) edge_in();
      chk("t1_mask", mask, 32'h1110);
      chk("t1_pc", 32'(period_count), 3);
      chk("t1_ndone", n_done, 1);
      chk("t1_done_gap", done_gap, 1);
      chk("t1_busy_at_done", 32'(busy_at_done), 0);
      chk("t1_busy_end", 32'(busy), 0);

      // divisor 1, free-run, then stop
      clr();
      go(1, 0);
      repeat (5) edge_in();
      chk("t2_ndiv", n_div, 5);
      chk("t2_mask", mask, 32'h3e);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("t2_busy", 32'(busy), 0);
      chk("t2_ndone", n_done, 0);
      chk("t2_pc", 32'(period_count), 5);

      // divisor 0 rejected
      clr();
      go(0, 2);
      chk("t3_err", 32'(cfg_error), 1);
      chk("t3_busy", 32'(busy), 0);
      step();
      chk("t3_err_pulse", 32'(cfg_error), 0);
      chk("t3_nerr", n_err, 1);
      chk("t3_pc_held", 32'(period_count), 5);

      // divisor 3, stop with 3rd edge
      clr();
      go(3, 0);
      repeat (2) edge_in();
      sig_in = 1'b1;
      repeat (3) step();
      chk("t4_pulse", 32'(dut.edge_pulse), 1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("t4_div", 32'(div_out), 0);
      chk("t4_busy", 32'(busy), 0);
      sig_in = 1'b0;
      repeat (4) step();
      chk("t4_ndiv", n_div, 0);
      chk("t4_pc", 32'(period_count), 0);

      // reset mid-run, then fresh start
      clr();
      go(10, 0);
      repeat (6) edge_in();
      chk("t5_busy_pre", 32'(busy), 1);
      reset_n = 1'b0;
      #1;
      chk("t5_rst_outs", {28'd0, busy, div_out, done, cfg_error}, 0);
      chk("t5_rst_pc", 32'(period_count), 0);
      #2;
      reset_n = 1'b1;
      step();
      clr();
      go(10, 0);
      repeat (10) edge_in();
      chk("t5_mask", mask, 32'h400);
      chk("t5_pc", 32'(period_count), 1);
      stop = 1'b1;
      step();
      stop = 1'b0;

      // start while busy is ignored
      clr();
      go(5, 1);
      repeat (2) edge_in();
      go(2, 0);
      chk("t6_busy", 32'(busy), 1);
      repeat (4) edge_in();
      chk("t6_mask", mask, 32'h20);
      chk("t6_ndone", n_done, 1);
      chk("t6_pc", 32'(period_count), 1);
      chk("t6_err", n_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
